carfield_addr_rule_table: RTL

Runtime-programmable address rule table for the Carfield host domain. It holds `NumRules` enable/base/size windows in registers, loaded at reset from the shared Carfield defaults. Windows are edited through a 64-bit register port with shadow-and-commit semantics and an optional sticky lock. A pipelined, valid/ready-handshaked decode port maps an address to the lowest-index matching rule, flags multi-hits, and feeds the crossbar's address-rule generation and the debug path.

---
 rtl/carfield_addr_rule_table_pkg.sv | 37 +++
 rtl/carfield_addr_rule_table_if.sv | 34 +++
 rtl/carfield_addr_rule_table_match.sv | 12 +
 rtl/carfield_addr_rule_table.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/carfield_addr_rule_table_pkg.sv
// carfield_addr_rule_pkg: rule type, register map offsets and the Carfield default windows
package carfield_addr_rule_pkg;

    typedef logic [63:0] doub_bt;

    typedef struct packed {
        doub_bt en;
        doub_bt base;
        doub_bt size;
    } addr_rule_t;

    localparam int MaxRules = 16;

    localparam logic [4:0] RegCtrl    = 5'h00;
    localparam logic [4:0] RegBaseSh  = 5'h08;
    localparam logic [4:0] RegSizeSh  = 5'h10;
    localparam logic [4:0] RegActBase = 5'h18;
    localparam logic [7:0] RegLock    = 8'hF8;

    localparam int CtrlEnBit     = 0;
    localparam int CtrlCommitBit = 1;

    localparam addr_rule_t NoRule = '0;

    // mailbox, L2 port 0, L2 port 1, safety island, PULP cluster, Spatz cluster, peripherals
    localparam addr_rule_t DefaultRules [MaxRules] = '{
        '{en: 64'd1, base: 64'h0000_4000_0000, size: 64'h0000_0000_1000},
        '{en: 64'd1, base: 64'h0000_7800_0000, size: 64'h0000_0020_0000},
        '{en: 64'd1, base: 64'h0000_7820_0000, size: 64'h0000_0020_0000},
        '{en: 64'd1, base: 64'h0000_6000_0000, size: 64'h0000_0080_0000},
        '{en: 64'd1, base: 64'h0000_5000_0000, size: 64'h0000_0080_0000},
        '{en: 64'd1, base: 64'h0000_5100_0000, size: 64'h0000_0080_0000},
        '{en: 64'd1, base: 64'h0000_2000_1000, size: 64'h0000_0000_9000},
        NoRule, NoRule, NoRule, NoRule, NoRule, NoRule, NoRule, NoRule, NoRule
    };

endpackage

// File: rtl/carfield_addr_rule_table_if.sv
// carfield_addr_rule_table_if: config register port and decode handshake of the rule table
interface carfield_addr_rule_table_if #(
    parameter int AddrWidth = 48,
    parameter int IdxWidth  = 3
);
    logic                 cfg_req_i;
    logic                 cfg_we_i;
    logic [7:0]           cfg_addr_i;
    logic [63:0]          cfg_wdata_i;
    logic                 cfg_gnt_o;
    logic                 cfg_rvalid_o;
    logic [63:0]          cfg_rdata_o;
    logic                 cfg_err_o;
    logic                 dec_valid_i;
    logic                 dec_ready_o;
    logic [AddrWidth-1:0] dec_addr_i;
    logic                 dec_valid_o;
    logic                 dec_ready_i;
    logic                 dec_hit_o;
    logic [IdxWidth-1:0]  dec_idx_o;
    logic                 dec_multi_o;

    modport slave (
        input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, dec_valid_i, dec_addr_i, dec_ready_i,
        output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o, dec_ready_o, dec_valid_o,
               dec_hit_o, dec_idx_o, dec_multi_o
    );

    modport master (
        output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, dec_valid_i, dec_addr_i, dec_ready_i,
        input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o, dec_ready_o, dec_valid_o,
               dec_hit_o, dec_idx_o, dec_multi_o
    );
endinterface

// File: rtl/carfield_addr_rule_table_match.sv
// carfield_addr_rule_match: single-window comparator, overflow-free at the top of the address space
module carfield_addr_rule_match #(
    parameter int AddrWidth = 48
) (
    input  logic                 en_i,
    input  logic [AddrWidth-1:0] base_i,
    input  logic [AddrWidth-1:0] size_i,
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 match_o
);
    assign match_o = en_i && (addr_i >= base_i) && ((addr_i - base_i) < size_i);
endmodule

// File: rtl/carfield_addr_rule_table.sv
// carfield_addr_rule_table: shadow/commit programmable windows with pipelined priority decode; sticky LOCK under CARFIELD_ADDR_RULE_LOCK_EN
module carfield_addr_rule_table
    import carfield_addr_rule_pkg::*;
#(
    parameter int NumRules  = 8,
    parameter int AddrWidth = 48,
    parameter int IdxWidth  = (NumRules > 1) ? $clog2(NumRules) : 1
) (
    input logic clk_i,
    input logic rst_i,
    carfield_addr_rule_table_if.slave bus
);
    logic [NumRules-1:0]  en_q, en_d;
    logic [AddrWidth-1:0] base_q    [NumRules];
    logic [AddrWidth-1:0] base_d    [NumRules];
    logic [AddrWidth-1:0] size_q    [NumRules];
    logic [AddrWidth-1:0] size_d    [NumRules];
    logic [AddrWidth-1:0] base_sh_q [NumRules];
    logic [AddrWidth-1:0] base_sh_d [NumRules];
    logic [AddrWidth-1:0] size_sh_q [NumRules];
    logic [AddrWidth-1:0] size_sh_d [NumRules];
    logic                 lock_q;
    logic                 rvalid_q, err_q, err_d;
    logic [63:0]          rdata_q, rdata_d;
    logic [2:0]           sel;
    logic [4:0]           off;
    logic                 is_lock, bad, wr_rule, unused_wdata;

    assign sel          = bus.cfg_addr_i[7:5];
    assign off          = bus.cfg_addr_i[4:0];
    assign is_lock      = bus.cfg_addr_i == RegLock;
    assign unused_wdata = ^bus.cfg_wdata_i;

    // LOCK aliases the last slot of rule 7, so it is decoded before the per-rule map
    assign bad = (off[2:0] != 3'd0)
              || (!is_lock && ((32'(sel) >= NumRules) || (bus.cfg_we_i && off == RegActBase)))
              || (bus.cfg_we_i && lock_q);
    assign wr_rule = bus.cfg_req_i && bus.cfg_we_i && !bad && !is_lock;
    assign err_d   = bus.cfg_req_i && bad;

`ifdef CARFIELD_ADDR_RULE_LOCK_EN
    always_ff @(posedge clk_i)
        lock_q <= rst_i ? 1'b0
                        : lock_q | (bus.cfg_req_i && bus.cfg_we_i && !bad && is_lock && bus.cfg_wdata_i[0]);
`else
    assign lock_q = 1'b0;
`endif

    always_comb begin
        en_d      = en_q;
        base_d    = base_q;
        size_d    = size_q;
        base_sh_d = base_sh_q;
        size_sh_d = size_sh_q;
        if (wr_rule && off == RegCtrl) begin
            en_d[sel] = bus.cfg_wdata_i[CtrlEnBit];
            if (bus.cfg_wdata_i[CtrlCommitBit]) begin
                base_d[sel] = base_sh_q[sel];
                size_d[sel] = size_sh_q[sel];
            end
        end
        if (wr_rule && off == RegBaseSh) base_sh_d[sel] = bus.cfg_wdata_i[AddrWidth-1:0];
        if (wr_rule && off == RegSizeSh) size_sh_d[sel] = bus.cfg_wdata_i[AddrWidth-1:0];
    end

    always_comb begin
        rdata_d = '0;
        if (bus.cfg_req_i && !bus.cfg_we_i && !bad)
            rdata_d = is_lock             ? 64'(lock_q)
                    : (off == RegCtrl)    ? 64'(en_q[sel])
                    : (off == RegBaseSh)  ? 64'(base_sh_q[sel])
                    : (off == RegSizeSh)  ? 64'(size_sh_q[sel])
                    :                       64'(base_q[sel]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NumRules; r++) begin
                en_q[r]      <= DefaultRules[r].en[0];
                base_q[r]    <= DefaultRules[r].base[AddrWidth-1:0];
                size_q[r]    <= DefaultRules[r].size[AddrWidth-1:0];
                base_sh_q[r] <= DefaultRules[r].base[AddrWidth-1:0];
                size_sh_q[r] <= DefaultRules[r].size[AddrWidth-1:0];
            end
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            en_q      <= en_d;
            base_q    <= base_d;
            size_q    <= size_d;
            base_sh_q <= base_sh_d;
            size_sh_q <= size_sh_d;
            rvalid_q  <= bus.cfg_req_i;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.cfg_gnt_o    = bus.cfg_req_i;
    assign bus.cfg_rvalid_o = rvalid_q;
    assign bus.cfg_err_o    = err_q;
    assign bus.cfg_rdata_o  = rdata_q;

    logic [NumRules-1:0] match;
    logic [IdxWidth-1:0] idx, idx_q;
    logic                accept, dec_valid_q, hit_q, multi_q;

    for (genvar g = 0; g < NumRules; g++) begin : g_match
        carfield_addr_rule_match #(.AddrWidth(AddrWidth)) u_match (
            .en_i    (en_q[g]),
            .base_i  (base_q[g]),
            .size_i  (size_q[g]),
            .addr_i  (bus.dec_addr_i),
            .match_o (match[g])
        );
    end

    always_comb begin
        idx = '0;
        for (int r = NumRules - 1; r >= 0; r--) idx = match[r] ? IdxWidth'(r) : idx;
    end

    assign bus.dec_ready_o = !dec_valid_q || bus.dec_ready_i;
    assign accept          = bus.dec_valid_i && bus.dec_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dec_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            idx_q       <= '0;
            multi_q     <= 1'b0;
        end else begin
            dec_valid_q <= accept || (dec_valid_q && !bus.dec_ready_i);
            if (accept) begin
                hit_q   <= |match;
                idx_q   <= idx;
                multi_q <= |(match & (match - NumRules'(1)));
            end
        end
    end

    assign bus.dec_valid_o = dec_valid_q;
    assign bus.dec_hit_o   = hit_q;
    assign bus.dec_idx_o   = idx_q;
    assign bus.dec_multi_o = multi_q;
endmodule
